spi_adc_scanner: RTL
====================

// Module: spi_adc_scanner
// PURPOSE
//  Parametrised multi-channel SPI ADC reader; successor to the single-sensor light-sensor reader.
//  Clocks FRAME_BITS-bit frames out of up to CHANNELS serial ADCs (e.g. ADC081S021 PMODs) on a shared sclk/sdata bus with per-channel chip selects.
//  Runs single-shot (trigger edge) or continuous round-robin scan; keeps one result per channel for the bus-side reader (data/oe).
// PARAMETERS
//  CHANNELS     1   number of ADCs / cs_n lines (1..8)
//  CLK_DIV      50  clk cycles per sclk half-period (>=1)
//  FRAME_BITS   16  sclk cycles per frame (2..32)
//  DATA_MSB     12  frame bit holding result MSB (frame bit FRAME_BITS-1 arrives first)
//  DATA_LSB     5   frame bit holding result LSB; DATA_MSB>=DATA_LSB, width <=32
//  QUIET_CYC    100 min clk cycles cs_n stays high between frames (>=1)
// PORTS
//  clk      in   1     system clock
//  rst      in   1     async active-high reset
//  trigger  in   1     single-shot start, rising-edge detected
//  cont     in   1     1 = continuous scan, 0 = single-shot
//  sdata    in   1     shared serial data from ADCs
//  sel      in   CH_W  channel whose result drives data (CH_W = CHANNELS>1 ? $clog2(CHANNELS) : 1)
//  oe       in   1     1 = data shows result[sel], 0 = data forced to 0
//  sclk     out  1     serial clock, idles high
//  cs_n     out  CHANNELS active-low chip selects, one-hot-low while active
//  busy     out  1     high from frame start through end of QUIET
//  done     out  1     1-cycle pulse when a frame's result is stored
//  done_ch  out  CH_W  channel of the frame that completed (valid with done)
//  data     out  32    result[sel] zero-extended, or 0 when oe=0
// BEHAVIOUR
//  - Reset (async): FSM IDLE, sclk=1, cs_n=all 1, busy=0, done=0, done_ch=0, channel ptr=0, all results=0, edge reg=0.
//  - Single clock; data is combinational from the result regs, sel and oe; all other outputs are registered.
//  - FSM: IDLE -> SETUP -> SHIFT -> DONE -> QUIET -> IDLE or SETUP.
//  - IDLE: start when cont=1, or when cont=0 and trigger rises (trigger high now, registered trigger low).
//  - Start sampled in cycle T: SETUP in T+1, cs_n[ptr]=0, busy=1.
//  - SETUP lasts CLK_DIV cycles with sclk=1.
//  - SHIFT: 2*FRAME_BITS half-periods of CLK_DIV cycles each; sclk falls first.
//    sdata is sampled in the cycle sclk rises; bits shift in MSB first.
//  - After the FRAME_BITS-th rising edge, go to DONE (one cycle) in cycle T+1+CLK_DIV*(2*FRAME_BITS+1).
//    In DONE: cs_n all 1, done=1, done_ch=ptr, result[ptr] = frame[DATA_MSB:DATA_LSB].
//  - QUIET: cs_n high for QUIET_CYC cycles, busy=1. Then ptr advances, wrapping CHANNELS-1 -> 0.
//    If cont=1, go to SETUP next; else go to IDLE (busy=0).
//  - A trigger edge while busy is ignored, not queued. Trigger held high yields exactly one frame.
//  - cont is sampled only at IDLE/QUIET exit. Clearing cont mid-frame finishes the current frame and QUIET, then idles.
//  - Exactly FRAME_BITS falling and FRAME_BITS rising sclk edges occur per cs_n-low window.
//    sclk never toggles with all cs_n high.
//  - sel >= CHANNELS reads 0.
//  - A result register updates only in DONE; reads are stable between done pulses.
//  - Reset mid-frame: cs_n and sclk go high immediately; the partial frame is discarded and results are cleared.
// STRUCTURE
//  - Shared package/include spi_adc_pkg: FSM state encoding (IDLE, SETUP, SHIFT, DONE, QUIET) and the CH_W width function.
//  - One sub-module spi_clk_div: terminal-count tick generator (CLK_DIV) with a clear input.
//    Its tick also drives the QUIET counter.
//  - Top level holds the FSM, shift register, bit counter, channel pointer and result array.
// TESTING  (bench: CLK_DIV=2, FRAME_BITS=16, DATA_MSB=12, DATA_LSB=5, QUIET_CYC=4, behavioural ADC model per cs_n)
//  1. Hold rst high mid-run, then release -> sclk=1, cs_n=all 1, busy=0, done=0, data=0 with oe=1.
//  2. CHANNELS=1, ADC returns 0xA5; trigger rises at T -> done at T+67.
//     Then data=0x000000A5 with oe=1, and data=0 with oe=0.
//  3. CHANNELS=2, cont=1, ADCs return 0x3C and 0xC3 -> done_ch sequence 0,1,0,1.
//     Result[0]=0x3C, result[1]=0xC3; only one cs_n low at a time.
//  4. Hold trigger high for 200 cycles, plus a second edge mid-SHIFT -> exactly one done pulse.
//  5. Assert rst during SHIFT bit 7 -> cs_n and sclk high that cycle, results 0.
//     A new trigger then returns the correct 0xA5.
//  6. Clear cont during a frame with CHANNELS=4 -> that frame completes (done, done_ch correct), busy drops after QUIET, no further frames.
//     Per-window monitor counts 16 sclk rises and cs_n high >= 4 cycles.

Source files
------------

// File: rtl/spi_adc_pkg.sv
// rtl/spi_adc_pkg.sv - shared FSM encoding and channel-width helper for the SPI ADC scanner
package spi_adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_DONE,
    ST_QUIET
  } state_t;

  function automatic int ch_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - terminal-count tick generator; one tick every CLK_DIV cycles unless cleared
module spi_clk_div #(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || cnt_q == TC) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick_o = !clr_i && (cnt_q == TC);

endmodule

// File: rtl/spi_adc_scanner.sv
// rtl/spi_adc_scanner.sv - multi-channel SPI ADC scanner: frame FSM, shift register, per-channel results
module spi_adc_scanner
  import spi_adc_pkg::*;
#(
  parameter int CHANNELS   = 1,
  parameter int CLK_DIV    = 50,
  parameter int FRAME_BITS = 16,
  parameter int DATA_MSB   = 12,
  parameter int DATA_LSB   = 5,
  parameter int QUIET_CYC  = 100,
  parameter int CH_W       = ch_w(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trigger,
  input  logic                cont,
  input  logic                sdata,
  input  logic [CH_W-1:0]     sel,
  input  logic                oe,
  output logic                sclk,
  output logic [CHANNELS-1:0] cs_n,
  output logic                busy,
  output logic                done,
  output logic [CH_W-1:0]     done_ch,
  output logic [31:0]         data
);

  localparam int RES_W       = DATA_MSB - DATA_LSB + 1;
  localparam int QUIET_TICKS = (QUIET_CYC + CLK_DIV - 1) / CLK_DIV;
  localparam int QW          = $clog2(QUIET_TICKS + 1);
  localparam logic [5:0]      LAST_HALF  = 6'(2 * FRAME_BITS - 1);
  localparam logic [QW-1:0]   LAST_QUIET = QW'(QUIET_TICKS - 1);
  localparam logic [CH_W-1:0] LAST_CH    = CH_W'(CHANNELS - 1);

  state_t                state_q, state_d;
  logic                  tick, clr, start, store;
  logic [5:0]            half_q, half_d;
  logic [QW-1:0]         quiet_q, quiet_d;
  logic [CH_W-1:0]       ptr_q, ptr_d;
  logic [31:0]           sh_q, sh_d;
  logic                  sample_q, sample_d;
  logic                  trig_q;
  logic                  sclk_q, sclk_d;
  logic [CHANNELS-1:0]   cs_n_q, cs_n_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [CH_W-1:0]       done_ch_q, done_ch_d;
  logic [RES_W-1:0]      res_q [CHANNELS];

  // QUIET is counted in divider ticks, rounded up so cs_n stays high at least QUIET_CYC cycles
  assign clr   = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign start = cont || (trigger && !trig_q);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr),
    .tick_o(tick)
  );

  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    quiet_d   = quiet_q;
    ptr_d     = ptr_q;
    sclk_d    = sclk_q;
    sample_d  = 1'b0;
    store     = 1'b0;
    done_ch_d = done_ch_q;
    sh_d      = sample_q ? {sh_q[30:0], sdata} : sh_q;

    unique case (state_q)
      ST_IDLE: begin
        sclk_d = 1'b1;
        if (start) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        if (tick) begin
          state_d = ST_SHIFT;
          half_d  = '0;
          sclk_d  = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (half_q == LAST_HALF) begin
            state_d   = ST_DONE;
            store     = 1'b1;
            done_ch_d = ptr_q;
          end else begin
            half_d   = half_q + 6'd1;
            sclk_d   = ~sclk_q;
            sample_d = ~sclk_q;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_QUIET;
        quiet_d = '0;
      end
      ST_QUIET: begin
        if (tick) begin
          if (quiet_q == LAST_QUIET) begin
            ptr_d   = (ptr_q == LAST_CH) ? '0 : ptr_q + CH_W'(1);
            state_d = cont ? ST_SETUP : ST_IDLE;
          end else begin
            quiet_d = quiet_q + QW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    cs_n_d = '1;
    if (state_d == ST_SETUP || state_d == ST_SHIFT) cs_n_d[ptr_d] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      half_q    <= '0;
      quiet_q   <= '0;
      ptr_q     <= '0;
      sh_q      <= '0;
      sample_q  <= 1'b0;
      trig_q    <= 1'b0;
      sclk_q    <= 1'b1;
      cs_n_q    <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      half_q    <= half_d;
      quiet_q   <= quiet_d;
      ptr_q     <= ptr_d;
      sh_q      <= sh_d;
      sample_q  <= sample_d;
      trig_q    <= trigger;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_ch_q <= done_ch_d;
    end
  end

  // Capture from sh_d so the final bit is included even when CLK_DIV is 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) res_q[i] <= '0;
    end else if (store) begin
      res_q[ptr_q] <= sh_d[DATA_MSB:DATA_LSB];
    end
  end

  always_comb begin
    data = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (oe && sel == CH_W'(i)) data = 32'(res_q[i]);
  end

  assign sclk    = sclk_q;
  assign cs_n    = cs_n_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_ch = done_ch_q;

endmodule
